// File: rtl/tdc_launch_ctrl.sv
// ---------------------------------------------------------------------------
// tdc_launch_ctrl
//
// Launch-side controller for the TDC delay line. A measurement launches an
// edge into the line, counts coarse clk cycles until a (synchronised) rising
// edge on stop_in, strobes the line's sample input, collects the fine count
// and presents {coarse, fine, timeout} on a valid/ready result port. After
// the result is taken, launch is held low for DRAIN_CYCLES so the line can
// clear before the next run is accepted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start / ready     measurement request, accepted when start & ready
//   stop_in           asynchronous stop; rising edge ends the run
//   launch            edge driven into delay_line signal_in
//   sample            one-cycle strobe to delay_line sample
//   dl_fine/dl_valid  fine count and valid from the delay line
//   res_coarse, res_fine, res_timeout, res_valid / res_ready
//                     result port
//
// Optional build macro TDC_LAUNCH_STATS_EN adds the saturating 16-bit
// counters stat_meas (result handshakes) and stat_timeouts (handshakes of a
// timeout result).
// ---------------------------------------------------------------------------
module tdc_launch_ctrl #(
    parameter int COARSE_W     = 16,
    parameter int FINE_W       = 6,
    parameter int TIMEOUT      = 1000,
    parameter int SYNC_STAGES  = 2,
    parameter int FINE_WAIT    = 4,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                ready,
    input  logic                stop_in,
    output logic                launch,
    output logic                sample,
    input  logic [FINE_W-1:0]   dl_fine,
    input  logic                dl_valid,
    output logic [COARSE_W-1:0] res_coarse,
    output logic [FINE_W-1:0]   res_fine,
    output logic                res_timeout,
    output logic                res_valid,
    input  logic                res_ready
`ifdef TDC_LAUNCH_STATS_EN
    ,
    output logic [15:0]         stat_meas,
    output logic [15:0]         stat_timeouts
`endif
);

    // One small counter serves both the fine-wait and the drain phases.
    localparam int CNT_MAX = (FINE_WAIT > DRAIN_CYCLES) ? FINE_WAIT : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [COARSE_W-1:0] TIMEOUT_C    = COARSE_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]    FINE_LAST_C  = CNT_W'(FINE_WAIT - 1);
    localparam logic [CNT_W-1:0]    DRAIN_LAST_C = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SAMPLE,
        S_WAIT_FINE,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [COARSE_W-1:0]   coarse_q, coarse_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  launch_q, launch_d;
    logic                  sample_q, sample_d;
    logic [COARSE_W-1:0]   res_coarse_q, res_coarse_d;
    logic [FINE_W-1:0]     res_fine_q, res_fine_d;
    logic                  res_timeout_q, res_timeout_d;
    logic                  res_valid_q, res_valid_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   stop_edge;

    // Synchroniser and edge detector run in every state; the FSM only
    // looks at stop_edge while in RUN, so edges elsewhere are dropped.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], stop_in};
        prev_d    = sync_q[SYNC_STAGES-1];
        stop_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_comb begin
        state_d       = state_q;
        coarse_d      = coarse_q;
        cnt_d         = cnt_q;
        launch_d      = launch_q;
        sample_d      = 1'b0;
        res_coarse_d  = res_coarse_q;
        res_fine_d    = res_fine_q;
        res_timeout_d = res_timeout_q;
        res_valid_d   = res_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    launch_d      = 1'b1;
                    coarse_d      = '0;
                    res_timeout_d = 1'b0;
                    state_d       = S_RUN;
                end
            end
            S_RUN: begin
                // Stop takes priority over a simultaneous timeout.
                if (stop_edge) begin
                    sample_d = 1'b1;   // strobe is high for the SAMPLE cycle
                    state_d  = S_SAMPLE;
                end else if (coarse_q == TIMEOUT_C) begin
                    res_timeout_d = 1'b1;
                    res_fine_d    = '0;
                    res_coarse_d  = TIMEOUT_C;
                    launch_d      = 1'b0;
                    res_valid_d   = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    coarse_d = coarse_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                cnt_d   = '0;
                state_d = S_WAIT_FINE;
            end
            S_WAIT_FINE: begin
                if (dl_valid) begin
                    res_fine_d   = dl_fine;
                    res_coarse_d = coarse_q;
                    launch_d     = 1'b0;
                    res_valid_d  = 1'b1;
                    state_d      = S_HOLD;
                end else if (cnt_q == FINE_LAST_C) begin
                    res_fine_d    = '0;
                    res_timeout_d = 1'b1;
                    res_coarse_d  = coarse_q;
                    launch_d      = 1'b0;
                    res_valid_d   = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST_C) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            coarse_q      <= '0;
            cnt_q         <= '0;
            launch_q      <= 1'b0;
            sample_q      <= 1'b0;
            res_coarse_q  <= '0;
            res_fine_q    <= '0;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b0;
            sync_q        <= '0;
            prev_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            coarse_q      <= coarse_d;
            cnt_q         <= cnt_d;
            launch_q      <= launch_d;
            sample_q      <= sample_d;
            res_coarse_q  <= res_coarse_d;
            res_fine_q    <= res_fine_d;
            res_timeout_q <= res_timeout_d;
            res_valid_q   <= res_valid_d;
            sync_q        <= sync_d;
            prev_q        <= prev_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign launch      = launch_q;
    assign sample      = sample_q;
    assign res_coarse  = res_coarse_q;
    assign res_fine    = res_fine_q;
    assign res_timeout = res_timeout_q;
    assign res_valid   = res_valid_q;

`ifdef TDC_LAUNCH_STATS_EN
    logic [15:0] stat_meas_q, stat_meas_d;
    logic [15:0] stat_timeouts_q, stat_timeouts_d;

    always_comb begin
        stat_meas_d     = stat_meas_q;
        stat_timeouts_d = stat_timeouts_q;
        if (res_valid_q && res_ready) begin
            if (stat_meas_q != 16'hFFFF) begin
                stat_meas_d = stat_meas_q + 16'd1;
            end
            if (res_timeout_q && (stat_timeouts_q != 16'hFFFF)) begin
                stat_timeouts_d = stat_timeouts_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_meas_q     <= '0;
            stat_timeouts_q <= '0;
        end else begin
            stat_meas_q     <= stat_meas_d;
            stat_timeouts_q <= stat_timeouts_d;
        end
    end

    assign stat_meas     = stat_meas_q;
    assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_tdc_launch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tdc_launch_ctrl
//
// Scoreboarded bench for tdc_launch_ctrl. The stimulus process issues runs
// (stop delay, fine response delay, fine value, result back-pressure), works
// out the expected result from the measurement rules and pushes it into a
// queue. A monitor pops and compares on every result handshake and checks
// that held results stay stable under back-pressure.
// ---------------------------------------------------------------------------
module tb_tdc_launch_ctrl;

    localparam int COARSE_W     = 16;
    localparam int FINE_W       = 6;
    localparam int TIMEOUT      = 1000;
    localparam int SYNC_STAGES  = 2;
    localparam int FINE_WAIT    = 4;
    localparam int DRAIN_CYCLES = 8;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                ready;
    logic                stop_in;
    logic                launch;
    logic                sample;
    logic [FINE_W-1:0]   dl_fine;
    logic                dl_valid;
    logic [COARSE_W-1:0] res_coarse;
    logic [FINE_W-1:0]   res_fine;
    logic                res_timeout;
    logic                res_valid;
    logic                res_ready;
`ifdef TDC_LAUNCH_STATS_EN
    logic [15:0]         stat_meas;
    logic [15:0]         stat_timeouts;
`endif

    tdc_launch_ctrl #(
        .COARSE_W    (COARSE_W),
        .FINE_W      (FINE_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES),
        .FINE_WAIT   (FINE_WAIT),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ready      (ready),
        .stop_in    (stop_in),
        .launch     (launch),
        .sample     (sample),
        .dl_fine    (dl_fine),
        .dl_valid   (dl_valid),
        .res_coarse (res_coarse),
        .res_fine   (res_fine),
        .res_timeout(res_timeout),
        .res_valid  (res_valid),
        .res_ready  (res_ready)
`ifdef TDC_LAUNCH_STATS_EN
        ,
        .stat_meas    (stat_meas),
        .stat_timeouts(stat_timeouts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int coarse;
        int fine;
        int tmo;
    } exp_t;

    exp_t sb_q[$];
    int   tests      = 0;
    int   fails      = 0;
    int   sample_cnt = 0;
    int   hs_cnt     = 0;
    int   tmo_cnt    = 0;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard pops on handshakes, stability while back-pressured.
    int   hold_snap;
    bit   holding;
    always @(negedge clk) begin
        if (!rst_n) begin
            holding = 1'b0;
        end else begin
            if (sample) sample_cnt++;
            if (res_valid) begin
                if (holding) begin
                    chk("hold_stable", int'({res_coarse, res_fine, res_timeout}), hold_snap);
                end else begin
                    hold_snap = int'({res_coarse, res_fine, res_timeout});
                    holding   = 1'b1;
                end
                if (res_ready) begin
                    holding = 1'b0;
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_result", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("res_coarse", int'(res_coarse), e.coarse);
                        chk("res_fine", int'(res_fine), e.fine);
                        chk("res_timeout", int'(res_timeout), e.tmo);
                        hs_cnt++;
                        if (e.tmo != 0) tmo_cnt++;
                    end
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    // One measurement. n: RUN edge after which stop_in rises (<0: never).
    // j: WAIT_FINE cycle (1-based) in which dl_valid pulses (0: never).
    // f: fine value. h: cycles of res_ready low once the result is up.
    task automatic do_run(input int n, input int j, input int f, input int h);
        exp_t e;
        bit   stopped;
        int   k;
        int   s0;
        int   lhigh;
        stopped  = (n >= 0) && (n + SYNC_STAGES <= TIMEOUT);
        e.coarse = stopped ? n + SYNC_STAGES : TIMEOUT;
        e.fine   = (stopped && j >= 1 && j <= FINE_WAIT) ? f : 0;
        e.tmo    = (stopped && j >= 1 && j <= FINE_WAIT) ? 0 : 1;

        k = 0;
        while (!ready && k < 100) begin tick; k++; end
        chk("ready_before_start", int'(ready), 1);
        s0 = sample_cnt;
        sb_q.push_back(e);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("ready_after_start", int'(ready), 0);
        chk("launch_after_start", int'(launch), 1);

        if (n >= 0) begin
            repeat (n) tick;
            stop_in = 1'b1;
        end

        k = 0;
        while (!sample && !res_valid && k < TIMEOUT + 50) begin tick; k++; end
        if (sample && j > 0) begin
            repeat (j) tick;
            dl_valid = 1'b1;
            dl_fine  = FINE_W'(f);
            tick;
            dl_valid = 1'b0;
            dl_fine  = FINE_W'($urandom);
        end

        k = 0;
        while (!res_valid && k < 50) begin tick; k++; end
        chk("res_valid_seen", int'(res_valid), 1);
        chk("launch_in_hold", int'(launch), 0);
        chk("sample_pulses", sample_cnt - s0, stopped ? 1 : 0);

        for (int i = 0; i < h; i++) begin
            if (i == h / 2) start = 1'b1;
            tick;
            start = 1'b0;
        end
        if (h > 0) begin
            chk("hold_ready_low", int'(ready), 0);
            chk("hold_valid", int'(res_valid), 1);
        end

        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("valid_after_hs", int'(res_valid), 0);

        k     = 0;
        lhigh = 0;
        while (!ready && k < 50) begin
            if (launch) lhigh++;
            tick;
            k++;
        end
        chk("drain_len", k, DRAIN_CYCLES);
        chk("drain_launch_low", lhigh, 0);
        stop_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stop_in   = 1'b0;
        dl_fine   = '0;
        dl_valid  = 1'b0;
        res_ready = 1'b0;
        repeat (2) tick;

        chk("rst_ready", int'(ready), 1);
        chk("rst_launch", int'(launch), 0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_timeout", int'(res_timeout), 0);
        chk("rst_res_coarse", int'(res_coarse), 0);
        chk("rst_res_fine", int'(res_fine), 0);
        rst_n = 1'b1;
        tick;

        do_run(10, 1, 37, 20);                           // nominal
        do_run(20, 0, 0, 3);                             // fine never arrives
        do_run(-1, 0, 0, 2);                             // no stop: timeout
        do_run(TIMEOUT - SYNC_STAGES, 2, 11, 1);         // stop wins at TIMEOUT
        do_run(TIMEOUT - SYNC_STAGES + 1, 1, 5, 0);      // timeout first
        do_run(7, FINE_WAIT, 63, 0);                     // last fine cycle
        do_run(7, FINE_WAIT + 1, 9, 0);                  // one cycle too late
        repeat (15) begin
            do_run($urandom_range(1, 60), $urandom_range(0, 6),
                   $urandom_range(0, 63), $urandom_range(0, 5));
        end

`ifdef TDC_LAUNCH_STATS_EN
        chk("stat_meas", int'(stat_meas), hs_cnt);
        chk("stat_timeouts", int'(stat_timeouts), tmo_cnt);
`endif

        // Reset in the middle of RUN: launch must drop with no clock edge.
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        chk("run_launch_before_rst", int'(launch), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_launch", int'(launch), 0);
        chk("async_rst_ready", int'(ready), 1);
        chk("async_rst_valid", int'(res_valid), 0);
        tick;
        rst_n = 1'b1;
        tick;

        do_run(4, 1, 1, 0);                              // recovers after reset

        chk("sb_leftover", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
